// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, exception codes and field positions
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

endpackage

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - Coprocessor 0: SR/Cause/EPC/PRId and interrupt/exception arbitration
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2023_0007,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] vpc_aligned;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req     = (|(hw_int & im)) & ie & ~exl;
  assign exc_req     = (exc_in != EXC_INT) & ~exl;
  assign req         = int_req | exc_req;
  assign vpc_aligned = vpc & 32'hFFFF_FFFC;
  assign epc_out     = epc;
  assign exc_pc      = req ? HANDLER : epc;

  always_comb begin
    sr_word                        = '0;
    sr_word[SR_IM_HI:SR_IM_LO]     = im;
    sr_word[SR_EXL_BIT]            = exl;
    sr_word[SR_IE_BIT]             = ie;
    cause_word                     = '0;
    cause_word[CAUSE_BD_BIT]       = bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
  end

  always_comb begin
    case (cp0_addr)
      CP0_SR:    cp0_out = sr_word;
      CP0_CAUSE: cp0_out = cause_word;
      CP0_EPC:   cp0_out = epc;
      CP0_PRID:  cp0_out = PRID;
      default:   cp0_out = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      // The M instruction is cancelled when req fires, so its mtc0/eret must not commit.
      if (req) begin
        exl      <= 1'b1;
        bd       <= bd_in;
        exc_code <= int_req ? EXC_INT : exc_in;
        epc      <= bd_in ? vpc_aligned - 32'd4 : vpc_aligned;
      end else begin
        if (we && cp0_addr == CP0_SR) begin
          im  <= cp0_in[SR_IM_HI:SR_IM_LO];
          exl <= cp0_in[SR_EXL_BIT];
          ie  <= cp0_in[SR_IE_BIT];
        end
        if (we && cp0_addr == CP0_EPC) begin
          epc <= cp0_in;
        end
        if (exl_clr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - scoreboard bench for cp0_unit with a word-level reference model
module tb_cp0_unit;

  localparam logic [31:0] PRID_V    = 32'h2023_0007;
  localparam logic [31:0] HANDLER_V = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  cp0_addr = 5'd0;
  logic [31:0] cp0_in = 32'h0;
  logic [31:0] cp0_out;
  logic [31:0] vpc = 32'h0;
  logic        bd_in = 1'b0;
  logic [4:0]  exc_in = 5'd0;
  logic [5:0]  hw_int = 6'd0;
  logic        exl_clr = 1'b0;
  logic        req;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;

  cp0_unit #(.PRID(PRID_V), .HANDLER(HANDLER_V)) dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
    .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_in(exc_in), .hw_int(hw_int),
    .exl_clr(exl_clr), .req(req), .exc_pc(exc_pc), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] exc_pc;
    logic [31:0] cp0_out;
    logic [31:0] epc_out;
  } exp_t;

  exp_t q[$];
  int   total_cnt = 0;
  int   pass_cnt = 0;
  int   step_id = 0;

  // Reference state kept as whole architectural words.
  logic [31:0] m_sr, m_cause, m_epc;
  bit          model_valid = 0;

  task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s step=%0d got=%08h exp=%08h", name, id, got, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("req", e.id, {31'b0, req}, {31'b0, e.req});
        check("exc_pc", e.id, exc_pc, e.exc_pc);
        check("cp0_out", e.id, cp0_out, e.cp0_out);
        check("epc_out", e.id, epc_out, e.epc_out);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] pc, input logic b, input logic [4:0] e,
                      input logic [5:0] h, input logic x);
    exp_t ex;
    bit ireq, ereq, rq;
    logic [31:0] pc_al;
    @(negedge clk);
    reset = r; we = w; cp0_addr = a; cp0_in = d; vpc = pc; bd_in = b;
    exc_in = e; hw_int = h; exl_clr = x;
    step_id++;
    if (model_valid) begin
      ireq = ((h & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
      ereq = (e != 5'd0) && !m_sr[1];
      rq = ireq || ereq;
      ex.id = step_id;
      ex.req = rq;
      ex.epc_out = m_epc;
      ex.exc_pc = rq ? HANDLER_V : m_epc;
      case (a)
        5'd12:   ex.cp0_out = m_sr;
        5'd13:   ex.cp0_out = m_cause;
        5'd14:   ex.cp0_out = m_epc;
        5'd15:   ex.cp0_out = PRID_V;
        default: ex.cp0_out = 32'h0;
      endcase
      q.push_back(ex);
      if (!r) begin
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(h) << 10);
        if (rq) begin
          pc_al = {pc[31:2], 2'b00};
          m_sr = m_sr | 32'h2;
          m_cause = (m_cause & 32'h0000_FC00) | (32'(b) << 31) | (32'(ireq ? 5'd0 : e) << 2);
          m_epc = b ? pc_al - 32'd4 : pc_al;
        end else begin
          if (w && a == 5'd12) m_sr = d & 32'h0000_FC03;
          if (w && a == 5'd14) m_epc = d;
          if (x) m_sr = m_sr & ~32'h2;
        end
      end
    end
    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      model_valid = 1;
    end
  endtask

  task automatic rd(input logic [4:0] a);
    step(0, 0, a, 32'h0, 32'h0, 0, 5'd0, 6'd0, 0);
  endtask

  initial begin : driver
    logic [4:0] codes [6];
    logic [4:0] a;
    int wait_cnt;
    codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd1};

    step(1, 0, 5'd15, 0, 0, 0, 0, 0, 0);
    step(1, 0, 5'd15, 0, 0, 0, 0, 0, 0);
    rd(5'd15); rd(5'd12); rd(5'd13); rd(5'd14); rd(5'd7);

    step(0, 1, 5'd12, 32'h0000_FC01, 32'h0, 0, 0, 6'd0, 0);
    step(0, 0, 5'd12, 0, 32'h0000_1000, 0, 0, 6'b000001, 0);
    step(0, 0, 5'd13, 0, 32'h0000_1004, 0, 0, 6'b000001, 0);
    step(0, 0, 5'd14, 0, 0, 0, 0, 6'b000001, 0);

    step(0, 0, 5'd12, 0, 32'h0000_2000, 0, 5'd8, 6'b000001, 0);
    step(0, 0, 5'd12, 0, 32'h0000_2004, 0, 0, 6'b000001, 1);
    step(0, 0, 5'd13, 0, 32'h0000_2008, 1, 0, 6'b000001, 0);
    step(0, 0, 5'd12, 0, 0, 0, 0, 6'd0, 1);

    step(0, 0, 5'd12, 0, 32'h0000_3010, 1, 5'd12, 6'd0, 0);
    rd(5'd13); rd(5'd14);
    step(0, 0, 5'd12, 0, 0, 0, 0, 6'd0, 1);

    step(0, 1, 5'd14, 32'hDEAD_BEEF, 32'h0000_2000, 0, 5'd4, 6'd0, 0);
    rd(5'd14);
    step(0, 0, 5'd12, 0, 0, 0, 0, 6'd0, 1);
    step(0, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 6'd0, 0);
    rd(5'd13);

    step(0, 0, 5'd12, 0, 32'h0, 1, 5'd10, 6'd0, 0);
    rd(5'd14);
    step(0, 0, 5'd12, 0, 0, 0, 0, 6'd0, 1);

    step(0, 1, 5'd14, 32'h0000_3000, 0, 0, 0, 6'd0, 0);
    step(0, 0, 5'd12, 0, 32'h0000_3000, 0, 5'd5, 6'd0, 0);
    step(1, 0, 5'd14, 0, 32'h0000_3004, 0, 5'd8, 6'd0, 0);
    rd(5'd12); rd(5'd13); rd(5'd14);
    step(1, 0, 5'd13, 0, 32'h0000_5000, 1, 5'd4, 6'd3, 0);
    rd(5'd13); rd(5'd14);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0: a = 5'd12;
        1: a = 5'd13;
        2: a = 5'd14;
        3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           a,
           ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_FC01 | ($urandom & 32'h3)),
           $urandom,
           1'($urandom),
           ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 5)] : 5'd0,
           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
           ($urandom_range(0, 4) == 0));
    end
    step(0, 0, 5'd0, 0, 0, 0, 0, 0, 0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
